// File: rtl/audio_fx_pkg.sv
// Shared definitions for the chop audio effect: the mode encodings carried on
// the 2-bit mode input.
package audio_fx_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_MUTE     = 2'b01,
    MODE_ATTEN    = 2'b10,
    MODE_PINGPONG = 2'b11
  } fx_mode_e;

endpackage

// File: rtl/audio_chan_fx.sv
// Per-channel chop effect: bypass, mute, attenuate or ping-pong a single
// sample depending on mode, the current gate phase and the channel's parity.
module audio_chan_fx
  import audio_fx_pkg::*;
#(
  parameter int SAMPLE_W    = 32,
  parameter int ATTEN_SHIFT = 3
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [1:0]          mode,
  input  logic                gate,
  input  logic                odd,
  output logic [SAMPLE_W-1:0] result
);

  logic signed [SAMPLE_W-1:0] signed_sample;
  logic signed [SAMPLE_W-1:0] shifted;

  assign signed_sample = $signed(sample);
  assign shifted       = signed_sample >>> ATTEN_SHIFT;

  always_comb begin
    result = sample;
    case (mode)
      MODE_BYPASS:   result = sample;
      MODE_MUTE:     if (gate) result = '0;
      MODE_ATTEN:    if (gate) result = shifted;
      // Even channels are silenced in the high phase, odd ones in the low phase.
      MODE_PINGPONG: if (gate != odd) result = '0;
      default:       result = sample;
    endcase
  end

endmodule

// File: rtl/audio_chop_fx.sv
// Chop audio effect: a square-wave phase generator gates the incoming stream
// through a one-entry buffer, applying the effect at the moment of acceptance.
module audio_chop_fx
  import audio_fx_pkg::*;
#(
  parameter int SAMPLE_W    = 32,
  parameter int NUM_CH      = 2,
  parameter int PERIOD_W    = 18,
  parameter int ATTEN_SHIFT = 3
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [PERIOD_W-1:0]        period,
  input  logic [1:0]                 mode,
  input  logic                       audio_in_available,
  input  logic [NUM_CH*SAMPLE_W-1:0] audio_in_data,
  output logic                       read_audio_in,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic [NUM_CH*SAMPLE_W-1:0] audio_out_data,
  output logic [15:0]                level_led,
  output logic                       gate
);

  logic [PERIOD_W-1:0]        phase_count;
  logic                       full;
  logic [NUM_CH*SAMPLE_W-1:0] processed;

  // Phase generator: a zero period parks the wave low.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      phase_count <= '0;
      gate        <= 1'b0;
    end else if (period == '0) begin
      phase_count <= '0;
      gate        <= 1'b0;
    end else if (phase_count >= period) begin
      phase_count <= '0;
      gate        <= ~gate;
    end else begin
      phase_count <= phase_count + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    audio_chan_fx #(
      .SAMPLE_W   (SAMPLE_W),
      .ATTEN_SHIFT(ATTEN_SHIFT)
    ) u_chan_fx (
      .sample(audio_in_data[k*SAMPLE_W +: SAMPLE_W]),
      .mode  (mode),
      .gate  (gate),
      .odd   ((k % 2) == 1),
      .result(processed[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  assign read_audio_in   = audio_in_available & (~full | audio_out_allowed);
  assign write_audio_out = full & audio_out_allowed;

  // The buffer holds the already-processed sample, so later mode or gate
  // changes cannot alter what is waiting to go out.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      full           <= 1'b0;
      audio_out_data <= '0;
      level_led      <= '0;
    end else begin
      if (write_audio_out) begin
        level_led <= audio_out_data[SAMPLE_W-1 -: 16];
      end
      if (read_audio_in) begin
        audio_out_data <= processed;
        full           <= 1'b1;
      end else if (write_audio_out) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_chop_fx.sv
// Directed bench for audio_chop_fx: table of effect vectors plus hand-written
// sequences for the phase generator, backpressure and reset corners.
module tb_audio_chop_fx;

  localparam int SAMPLE_W = 32;
  localparam int NUM_CH   = 2;
  localparam int PERIOD_W = 18;

  logic                       CLOCK_50 = 1'b0;
  logic                       reset;
  logic [PERIOD_W-1:0]        period;
  logic [1:0]                 mode;
  logic                       audio_in_available;
  logic [NUM_CH*SAMPLE_W-1:0] audio_in_data;
  logic                       read_audio_in;
  logic                       audio_out_allowed;
  logic                       write_audio_out;
  logic [NUM_CH*SAMPLE_W-1:0] audio_out_data;
  logic [15:0]                level_led;
  logic                       gate;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        gate;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[9];

  audio_chop_fx #(
    .SAMPLE_W(SAMPLE_W), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .ATTEN_SHIFT(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .period(period), .mode(mode),
    .audio_in_available(audio_in_available), .audio_in_data(audio_in_data),
    .read_audio_in(read_audio_in), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .audio_out_data(audio_out_data),
    .level_led(level_led), .gate(gate)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Park the phase generator so gate holds the requested level for a long time.
  task automatic set_gate(input logic g);
    period = '0;
    tick();
    tick();
    if (g) begin
      period = 18'd1;
      tick();
      tick();
      period = '1;
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    audio_in_available = 1'b0;
    audio_out_allowed  = 1'b0;
    #12;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
    vecs[1] = '{2'b00, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
    vecs[2] = '{2'b01, 1'b1, 32'h12345678, 32'hCAFEBABE, 32'h00000000, 32'h00000000};
    vecs[3] = '{2'b01, 1'b0, 32'h12345678, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE};
    vecs[4] = '{2'b10, 1'b1, 32'h80000000, 32'h7FFFFFF8, 32'hF0000000, 32'h0FFFFFFF};
    vecs[5] = '{2'b10, 1'b1, 32'hFFFFFFF9, 32'h00000010, 32'hFFFFFFFF, 32'h00000002};
    vecs[6] = '{2'b10, 1'b0, 32'h80000000, 32'h12345678, 32'h80000000, 32'h12345678};
    vecs[7] = '{2'b11, 1'b1, 32'h11112222, 32'h33334444, 32'h00000000, 32'h33334444};
    vecs[8] = '{2'b11, 1'b0, 32'h11112222, 32'h33334444, 32'h11112222, 32'h00000000};

    period        = '0;
    mode          = 2'b00;
    audio_in_data = '0;
    do_reset();

    check_output("reset_gate", 64'(gate), 64'd0);
    check_output("reset_write", 64'(write_audio_out), 64'd0);
    check_output("reset_out_data", audio_out_data, 64'd0);
    check_output("reset_level", 64'(level_led), 64'd0);
    audio_in_available = 1'b1;
    #1;
    check_output("reset_read_follows_avail", 64'(read_audio_in), 64'd1);
    audio_in_available = 1'b0;

    // Table-driven effect vectors, each accepted then drained immediately.
    for (int i = 0; i < 9; i++) begin
      set_gate(vecs[i].gate);
      check_output($sformatf("v%0d_gate", i), 64'(gate), 64'(vecs[i].gate));
      mode               = vecs[i].mode;
      audio_in_data      = {vecs[i].in1, vecs[i].in0};
      audio_in_available = 1'b1;
      audio_out_allowed  = 1'b1;
      #1;
      check_output($sformatf("v%0d_read", i), 64'(read_audio_in), 64'd1);
      tick();
      audio_in_available = 1'b0;
      #1;
      check_output($sformatf("v%0d_write", i), 64'(write_audio_out), 64'd1);
      check_output($sformatf("v%0d_data", i), audio_out_data, {vecs[i].exp1, vecs[i].exp0});
      tick();
      check_output($sformatf("v%0d_level", i), 64'(level_led), 64'(vecs[i].exp0[31:16]));
      check_output($sformatf("v%0d_idle", i), 64'(write_audio_out), 64'd0);
    end

    // Period 4: gate toggles every 5 edges after reset.
    period = 18'd4;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_output($sformatf("p4_gate_e%0d", k), 64'(gate), 64'((k / 5) % 2));
    end

    // Period 10 lowered to 2 at count 7 wraps on the next edge.
    period = 18'd10;
    do_reset();
    for (int k = 1; k <= 7; k++) tick();
    check_output("p10_gate_at7", 64'(gate), 64'd0);
    period = 18'd2;
    tick();
    check_output("p2_wrap_gate", 64'(gate), 64'd1);
    tick();
    tick();
    check_output("p2_gate_cnt2", 64'(gate), 64'd1);
    tick();
    check_output("p2_gate_toggle", 64'(gate), 64'd0);

    // Backpressure: second sample stalls, then drain and accept together.
    period = '0;
    do_reset();
    mode               = 2'b00;
    audio_in_data      = {32'hAAAA0001, 32'hA5A51111};
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b0;
    #1;
    check_output("bp_first_read", 64'(read_audio_in), 64'd1);
    tick();
    audio_in_data = {32'hBBBB0002, 32'h5A5A2222};
    #1;
    check_output("bp_stall_read", 64'(read_audio_in), 64'd0);
    check_output("bp_stall_write", 64'(write_audio_out), 64'd0);
    tick();
    check_output("bp_hold_data", audio_out_data, {32'hAAAA0001, 32'hA5A51111});
    audio_out_allowed = 1'b1;
    #1;
    check_output("bp_both_write", 64'(write_audio_out), 64'd1);
    check_output("bp_both_read", 64'(read_audio_in), 64'd1);
    tick();
    audio_in_available = 1'b0;
    audio_out_allowed  = 1'b0;
    #1;
    check_output("bp_second_data", audio_out_data, {32'hBBBB0002, 32'h5A5A2222});
    check_output("bp_second_wait", 64'(write_audio_out), 64'd0);
    check_output("bp_level_first", 64'(level_led), 64'h0000_0000_0000_A5A5);
    audio_out_allowed = 1'b1;
    #1;
    check_output("bp_second_write", 64'(write_audio_out), 64'd1);
    tick();
    check_output("bp_drained", 64'(write_audio_out), 64'd0);
    check_output("bp_level_second", 64'(level_led), 64'h0000_0000_0000_5A5A);

    // A mode change after acceptance leaves the buffered sample untouched.
    set_gate(1'b1);
    mode               = 2'b01;
    audio_in_data      = {32'h12345678, 32'h12345678};
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b0;
    tick();
    audio_in_available = 1'b0;
    mode               = 2'b00;
    tick();
    check_output("mode_change_kept", audio_out_data, 64'd0);
    audio_out_allowed = 1'b1;
    tick();

    // Reset while full discards the buffered sample.
    mode               = 2'b00;
    period             = '0;
    audio_in_data      = {32'hDEAD0003, 32'hBEEF3333};
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b0;
    tick();
    audio_in_available = 1'b0;
    #2;
    reset             = 1'b1;
    audio_out_allowed = 1'b1;
    #1;
    check_output("rst_write", 64'(write_audio_out), 64'd0);
    check_output("rst_level", 64'(level_led), 64'd0);
    check_output("rst_data", audio_out_data, 64'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("rst_no_emit_%0d", k), 64'(write_audio_out), 64'd0);
    end
    check_output("rst_level_after", 64'(level_led), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
